// File: rtl/hazard_unit_param.sv
// Hazard controller beside decode: tracks in-flight destinations, picks forwarding
// sources, raises load-use / interlock stalls and times the post-jump flush window.
module hazard_unit_param #(
  parameter int unsigned REG_W        = 5,
  parameter int unsigned DEPTH        = 3,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned FWD          = 1,
  parameter int unsigned SEL_W        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jump_taken,
  input  logic             dcache_stall,
  input  logic             icache_stall,
  input  logic             id_valid,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             rs1_used,
  input  logic             rs2_used,
  input  logic [REG_W-1:0] rd,
  input  logic             rd_wr,
  input  logic             rd_is_load,
  output logic             stall,
  output logic             data_hazard,
  output logic             control_hazard,
  output logic [SEL_W-1:0] fwd_sel1,
  output logic [SEL_W-1:0] fwd_sel2
);

  localparam int unsigned CNT_W = 4;

  logic [DEPTH:1]   vld_q, vld_d;
  logic [DEPTH:1]   ld_q, ld_d;
  logic [REG_W-1:0] rd_q [1:DEPTH];
  logic [REG_W-1:0] rd_d [1:DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DEPTH:1]   hit1, hit2;
  logic             ins;

  assign stall          = dcache_stall | icache_stall;
  assign control_hazard = (cnt_q != '0);

  // x0 is hardwired, so a zero source never matches a tracked producer
  always_comb begin
    hit1 = '0;
    hit2 = '0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      hit1[k] = rs1_used && (rs1 != '0) && vld_q[k] && (rd_q[k] == rs1);
      hit2[k] = rs2_used && (rs2 != '0) && vld_q[k] && (rd_q[k] == rs2);
    end
  end

  // Scan oldest to youngest so the youngest producer overwrites the select
  always_comb begin
    fwd_sel1    = '0;
    fwd_sel2    = '0;
    data_hazard = 1'b0;
    if (FWD != 0) begin
      for (int unsigned k = DEPTH; k >= 1; k--) begin
        if (hit1[k]) fwd_sel1 = SEL_W'(k);
        if (hit2[k]) fwd_sel2 = SEL_W'(k);
      end
      data_hazard = id_valid && !control_hazard && ld_q[1] && (hit1[1] || hit2[1]);
    end else begin
      data_hazard = id_valid && !control_hazard && ((|hit1) || (|hit2));
    end
  end

  always_comb begin
    vld_d = vld_q;
    ld_d  = ld_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    ins   = id_valid && rd_wr && (rd != '0) && !data_hazard && !control_hazard;
    if (!stall) begin
      for (int unsigned k = 2; k <= DEPTH; k++) begin
        vld_d[k] = vld_q[k-1];
        ld_d[k]  = ld_q[k-1];
        rd_d[k]  = rd_q[k-1];
      end
      vld_d[1] = ins;
      ld_d[1]  = ins && rd_is_load;
      rd_d[1]  = ins ? rd : '0;
      // A new jump reloads the window even while a previous flush is running
      if (jump_taken)         cnt_d = CNT_W'(FLUSH_CYCLES);
      else if (cnt_q != '0)   cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      ld_q  <= '0;
      cnt_q <= '0;
      for (int unsigned k = 1; k <= DEPTH; k++) rd_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      ld_q  <= ld_d;
      cnt_q <= cnt_d;
      for (int unsigned k = 1; k <= DEPTH; k++) rd_q[k] <= rd_d[k];
    end
  end

endmodule

// File: tb/tb_hazard_unit_param.sv
// Randomized scoreboard bench: a forwarding instance and an interlock instance
// share stimulus and are checked against a queue-based reference model.
module tb_hazard_unit_param;

  logic clk = 1'b0;
  logic rst, jump_taken, dcache_stall, icache_stall, id_valid;
  logic rs1_used, rs2_used, rd_wr, rd_is_load;
  logic [4:0] rs1, rs2, rd;

  logic st0, dh0, ch0;
  logic [1:0] s10, s20;
  logic st1, dh1, ch1;
  logic [2:0] s11, s21;

  always #5 clk = ~clk;

  hazard_unit_param #(.REG_W(5), .DEPTH(3), .FLUSH_CYCLES(2), .FWD(1)) u_fwd (
    .clk(clk), .rst(rst), .jump_taken(jump_taken), .dcache_stall(dcache_stall),
    .icache_stall(icache_stall), .id_valid(id_valid), .rs1(rs1), .rs2(rs2),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .rd(rd), .rd_wr(rd_wr),
    .rd_is_load(rd_is_load), .stall(st0), .data_hazard(dh0),
    .control_hazard(ch0), .fwd_sel1(s10), .fwd_sel2(s20));

  hazard_unit_param #(.REG_W(5), .DEPTH(4), .FLUSH_CYCLES(3), .FWD(0)) u_ilk (
    .clk(clk), .rst(rst), .jump_taken(jump_taken), .dcache_stall(dcache_stall),
    .icache_stall(icache_stall), .id_valid(id_valid), .rs1(rs1), .rs2(rs2),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .rd(rd), .rd_wr(rd_wr),
    .rd_is_load(rd_is_load), .stall(st1), .data_hazard(dh1),
    .control_hazard(ch1), .fwd_sel1(s11), .fwd_sel2(s21));

  typedef struct {
    bit       v;
    bit [4:0] r;
    bit       ld;
  } ent_t;

  typedef struct {
    bit st;
    bit dh0; bit ch0; int a0; int b0;
    bit dh1; bit ch1; int a1; int b1;
  } exp_t;

  // Model: per instance, list of producers by age (index 1 = youngest) and flush budget
  ent_t pipe [2][1:8];
  int   cnt  [2];
  int   dep  [2] = '{3, 4};
  int   fcy  [2] = '{2, 3};
  bit   fwd  [2] = '{1'b1, 1'b0};

  exp_t expq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic bit hit(int m, logic [4:0] s, logic used, int k);
    return used && (s != 0) && pipe[m][k].v && (pipe[m][k].r == s);
  endfunction

  function automatic void clear_model();
    for (int m = 0; m < 2; m++) begin
      cnt[m] = 0;
      for (int k = 1; k <= 8; k++) pipe[m][k] = '{v: 1'b0, r: 5'd0, ld: 1'b0};
    end
  endfunction

  function automatic void predict(int m, output bit dh, output bit ch,
                                  output int a, output int b);
    bit any;
    ch = (cnt[m] != 0);
    a = 0; b = 0; dh = 1'b0; any = 1'b0;
    for (int k = 1; k <= dep[m]; k++) begin
      if (hit(m, rs1, rs1_used, k) || hit(m, rs2, rs2_used, k)) any = 1'b1;
      if (fwd[m]) begin
        if (a == 0 && hit(m, rs1, rs1_used, k)) a = k;
        if (b == 0 && hit(m, rs2, rs2_used, k)) b = k;
      end
    end
    if (fwd[m])
      dh = id_valid && !ch && pipe[m][1].ld &&
           (hit(m, rs1, rs1_used, 1) || hit(m, rs2, rs2_used, 1));
    else
      dh = id_valid && !ch && any;
  endfunction

  function automatic void advance(int m, bit dh, bit ch);
    bit v;
    for (int k = dep[m]; k >= 2; k--) pipe[m][k] = pipe[m][k-1];
    v = id_valid && rd_wr && (rd != 0) && !dh && !ch;
    pipe[m][1] = '{v: v, r: rd, ld: v && rd_is_load};
    if (jump_taken)      cnt[m] = fcy[m];
    else if (cnt[m] > 0) cnt[m] = cnt[m] - 1;
  endfunction

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUTs present a full output set, compared mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("stall_fwd", int'(st0), int'(e.st));
        check("stall_ilk", int'(st1), int'(e.st));
        check("dh_fwd",    int'(dh0), int'(e.dh0));
        check("ch_fwd",    int'(ch0), int'(e.ch0));
        check("sel1_fwd",  int'(s10), e.a0);
        check("sel2_fwd",  int'(s20), e.b0);
        check("dh_ilk",    int'(dh1), int'(e.dh1));
        check("ch_ilk",    int'(ch1), int'(e.ch1));
        check("sel1_ilk",  int'(s11), e.a1);
        check("sel2_ilk",  int'(s21), e.b1);
      end
    end
  end

  // Stimulus: drive just after the edge, push expected outputs, step the model
  initial begin
    exp_t e;
    rst = 1'b1; jump_taken = 1'b0; dcache_stall = 1'b0; icache_stall = 1'b0;
    id_valid = 1'b0; rs1_used = 1'b0; rs2_used = 1'b0; rd_wr = 1'b0; rd_is_load = 1'b0;
    rs1 = '0; rs2 = '0; rd = '0;
    clear_model();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc < 3)  rst = 1'b1;
      else if (rst) rst = ($urandom_range(0, 1) == 0);
      else          rst = ($urandom_range(0, 79) == 0);
      jump_taken   = ($urandom_range(0, 5) == 0);
      dcache_stall = ($urandom_range(0, 5) == 0);
      icache_stall = ($urandom_range(0, 5) == 0);
      id_valid     = ($urandom_range(0, 7) != 0);
      rs1_used     = ($urandom_range(0, 3) != 0);
      rs2_used     = ($urandom_range(0, 3) != 0);
      rd_wr        = ($urandom_range(0, 3) != 0);
      rd_is_load   = ($urandom_range(0, 2) == 0);
      rs1          = 5'($urandom_range(0, 3));
      rs2          = 5'($urandom_range(0, 3));
      rd           = 5'($urandom_range(0, 3));
      if (rst) clear_model();
      e.st = dcache_stall | icache_stall;
      predict(0, e.dh0, e.ch0, e.a0, e.b0);
      predict(1, e.dh1, e.ch1, e.a1, e.b1);
      expq.push_back(e);
      if (!rst && !e.st) begin
        advance(0, e.dh0, e.ch0);
        advance(1, e.dh1, e.ch1);
      end
    end
    repeat (4) @(negedge clk);
    if (expq.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d expected %0d pending", expq.size(), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
